// File: rtl/lockstep_checker.sv
// Lockstep comparator for the pipelined cpu against cpu_model. It compares up to
// NUM_CH bundles on each verify strobe and keeps a sticky PASS/FAIL/timeout verdict.
module lockstep_checker #(
    parameter int NUM_CH         = 9,
    parameter int WIDTH          = 128,
    parameter int MAX_ERR        = 1,
    parameter int HLT_SKEW       = 0,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      verify,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH*WIDTH-1:0]   dut_vec,
    input  logic [NUM_CH*WIDTH-1:0]   ref_vec,
    input  logic                      dut_hlt,
    input  logic                      ref_hlt,
    input  logic                      stall,
    input  logic                      flush,
    output logic [1:0]                state,
    output logic                      done,
    output logic [1:0]                fail_cause,
    output logic [NUM_CH-1:0]         mismatch_mask,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [CH_W-1:0]           first_ch,
    output logic [31:0]               first_cycle,
    output logic [31:0]               cycle_cnt,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    localparam logic [1:0]       CAUSE_NONE     = 2'b00;
    localparam logic [1:0]       CAUSE_MISMATCH = 2'b01;
    localparam logic [1:0]       CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0]       CAUSE_HALT     = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};
    localparam logic [31:0]      TIMEOUT_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      SKEW_LIMIT     = 32'(HLT_SKEW);
    localparam logic [31:0]      SKEW_SAT       = 32'(HLT_SKEW + 1);
    localparam logic [31:0]      MAX_ERR_W      = 32'(MAX_ERR);

    state_t             state_r, state_next_s;
    logic               done_r;
    logic [1:0]         fail_cause_r, cause_next_s;
    logic [NUM_CH-1:0]  mismatch_mask_r, mism_s;
    logic [CNT_W-1:0]   err_cnt_r, err_next_s;
    logic [CH_W-1:0]    first_ch_r, low_ch_s;
    logic [31:0]        first_cycle_r, cycle_cnt_r;
    logic [CNT_W-1:0]   stall_cnt_r, flush_cnt_r;
    logic [31:0]        skew_r, skew_next_s;
    logic               run_s, enter_s, hit_s, err_fail_s, skew_fail_s;

    // Per-channel compare; an equality that is not cleanly true (X/Z) counts as a mismatch.
    always_comb begin
        mism_s   = {NUM_CH{1'b0}};
        low_ch_s = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (dut_vec[i*WIDTH +: WIDTH] == ref_vec[i*WIDTH +: WIDTH]) begin
                mism_s[i] = 1'b0;
            end else begin
                mism_s[i] = ch_en[i];
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            low_ch_s = mism_s[i] ? CH_W'(i) : low_ch_s;
        end
    end

    // Qualified events for this cycle and the next value of the error and skew counters.
    always_comb begin
        run_s   = (state_r == ST_RUN);
        enter_s = (state_r != ST_RUN) && start;
        hit_s   = run_s && verify && (|mism_s);
        if (hit_s && (err_cnt_r != CNT_MAX)) begin
            err_next_s = err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_next_s = err_cnt_r;
        end
        if (dut_hlt != ref_hlt) begin
            skew_next_s = (skew_r >= SKEW_SAT) ? skew_r : skew_r + 32'd1;
        end else begin
            skew_next_s = 32'd0;
        end
        err_fail_s  = (32'(err_next_s) >= MAX_ERR_W);
        skew_fail_s = (skew_next_s > SKEW_LIMIT);
    end

    // Next-state and verdict selection, with the RUN exit priority applied in order.
    always_comb begin
        state_next_s = state_r;
        cause_next_s = fail_cause_r;
        case (state_r)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    cause_next_s = CAUSE_NONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (err_fail_s) begin
                    state_next_s = ST_FAIL;
                    cause_next_s = CAUSE_MISMATCH;
                end else if (skew_fail_s) begin
                    state_next_s = ST_FAIL;
                    cause_next_s = CAUSE_HALT;
                end else if (dut_hlt && ref_hlt) begin
                    state_next_s = ST_PASS;
                end else if (cycle_cnt_r == TIMEOUT_LAST) begin
                    state_next_s = ST_FAIL;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cause_next_s = CAUSE_NONE;
            end
        endcase
    end

    // State, verdict and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fail_cause_r <= CAUSE_NONE;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            fail_cause_r <= cause_next_s;
            done_r       <= (state_next_s == ST_PASS) || (state_next_s == ST_FAIL);
        end
    end

    // Statistics: cleared on entering RUN, updated only in RUN, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_mask_r <= {NUM_CH{1'b0}};
            err_cnt_r       <= {CNT_W{1'b0}};
            first_ch_r      <= {CH_W{1'b0}};
            first_cycle_r   <= 32'd0;
            cycle_cnt_r     <= 32'd0;
            stall_cnt_r     <= {CNT_W{1'b0}};
            flush_cnt_r     <= {CNT_W{1'b0}};
            skew_r          <= 32'd0;
        end else if (enter_s) begin
            mismatch_mask_r <= {NUM_CH{1'b0}};
            err_cnt_r       <= {CNT_W{1'b0}};
            first_ch_r      <= {CH_W{1'b0}};
            first_cycle_r   <= 32'd0;
            cycle_cnt_r     <= 32'd0;
            stall_cnt_r     <= {CNT_W{1'b0}};
            flush_cnt_r     <= {CNT_W{1'b0}};
            skew_r          <= 32'd0;
        end else if (run_s) begin
            if (verify) begin
                mismatch_mask_r <= mism_s;
            end
            err_cnt_r <= err_next_s;
            if (hit_s && (err_cnt_r == {CNT_W{1'b0}})) begin
                first_ch_r    <= low_ch_s;
                first_cycle_r <= cycle_cnt_r;
            end
            if (stall && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            skew_r <= skew_next_s;
            // The deciding cycle keeps its own index so the verdict reports where it happened.
            if (state_next_s == ST_RUN) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end
        end
    end

    assign state         = state_r;
    assign done          = done_r;
    assign fail_cause    = fail_cause_r;
    assign mismatch_mask = mismatch_mask_r;
    assign err_cnt       = err_cnt_r;
    assign first_ch      = first_ch_r;
    assign first_cycle   = first_cycle_r;
    assign cycle_cnt     = cycle_cnt_r;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;

endmodule

// File: tb/tb_lockstep_checker.sv
// Bench for lockstep_checker: two instances with different limits share one stimulus
// stream; final outputs are compared with a cycle-indexed model of the run rules.
module tb_lockstep_checker;

    localparam int NUM_CH = 9;
    localparam int WIDTH  = 128;
    localparam int LEN    = 110;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, verify = 1'b0;
    logic dut_hlt = 1'b0, ref_hlt = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH*WIDTH-1:0] dut_vec = '0, ref_vec = '0;

    logic [1:0]  a_state, a_cause, b_state, b_cause;
    logic        a_done, b_done;
    logic [8:0]  a_mask, b_mask;
    logic [15:0] a_err, a_st, a_fl;
    logic [3:0]  b_err, b_st, b_fl;
    logic [3:0]  a_fch, b_fch;
    logic [31:0] a_fcy, a_cyc, b_fcy, b_cyc;

    lockstep_checker #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_ERR(1), .HLT_SKEW(2),
                       .TIMEOUT_CYCLES(100), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .verify(verify), .ch_en(ch_en),
        .dut_vec(dut_vec), .ref_vec(ref_vec), .dut_hlt(dut_hlt), .ref_hlt(ref_hlt),
        .stall(stall), .flush(flush), .state(a_state), .done(a_done),
        .fail_cause(a_cause), .mismatch_mask(a_mask), .err_cnt(a_err),
        .first_ch(a_fch), .first_cycle(a_fcy), .cycle_cnt(a_cyc),
        .stall_cnt(a_st), .flush_cnt(a_fl));

    lockstep_checker #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_ERR(3), .HLT_SKEW(0),
                       .TIMEOUT_CYCLES(60), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .verify(verify), .ch_en(ch_en),
        .dut_vec(dut_vec), .ref_vec(ref_vec), .dut_hlt(dut_hlt), .ref_hlt(ref_hlt),
        .stall(stall), .flush(flush), .state(b_state), .done(b_done),
        .fail_cause(b_cause), .mismatch_mask(b_mask), .err_cnt(b_err),
        .first_ch(b_fch), .first_cycle(b_fcy), .cycle_cnt(b_cyc),
        .stall_cnt(b_st), .flush_cnt(b_fl));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [NUM_CH-1:0] diff_q [LEN];
    logic [NUM_CH-1:0] en_q   [LEN];
    logic ver_q [LEN];
    logic dh_q  [LEN];
    logic rh_q  [LEN];
    logic st_q  [LEN];
    logic fl_q  [LEN];
    bit   rnd_bit = 1'b0;
    bit   chk_restart = 1'b0;
    int   probe_t = -1;
    logic [8:0] probe_mask = '0;
    int   ex [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        for (int t = 0; t < LEN; t++) begin
            diff_q[t] = '0;
            en_q[t]   = 9'h1FF;
            ver_q[t]  = (t % 2 == 0);
            dh_q[t]   = 1'b0;
            rh_q[t]   = 1'b0;
            st_q[t]   = 1'b0;
            fl_q[t]   = 1'b0;
        end
        rnd_bit = 1'b0;
    endtask

    task automatic set_halts(input int td, input int tr);
        for (int t = 0; t < LEN; t++) begin
            dh_q[t] = (t >= td);
            rh_q[t] = (t >= tr);
        end
    endtask

    task automatic gen_random();
        int td, lead;
        clear_stim();
        rnd_bit = 1'b1;
        for (int t = 0; t < LEN; t++) begin
            diff_q[t] = ($urandom_range(15, 0) == 0) ? 9'(9'h001 << $urandom_range(8, 0)) : 9'h000;
            en_q[t]   = ($urandom_range(3, 0) == 0) ? 9'(9'h1FF & ~(9'h001 << $urandom_range(8, 0))) : 9'h1FF;
            ver_q[t]  = 1'($urandom_range(1, 0));
            st_q[t]   = 1'($urandom_range(1, 0));
            fl_q[t]   = 1'($urandom_range(1, 0));
        end
        td   = int'($urandom_range(95, 15));
        lead = int'($urandom_range(4, 0));
        if ($urandom_range(1, 0) == 1) set_halts(td, td + lead);
        else set_halts(td + lead, td);
    endtask

    task automatic apply(input int n);
        int bp;
        start = 1'b1; verify = 1'b0; stall = 1'b0; flush = 1'b0;
        dut_hlt = 1'b0; ref_hlt = 1'b0; ch_en = '0;
        tick();
        start = 1'b0;
        if (chk_restart) begin
            check("restart_state", 32'(b_state), 32'd1);
            check("restart_cnts", 32'(b_err) | 32'(b_st) | 32'(b_fl) | b_cyc | b_fcy, 32'd0);
            check("restart_misc", 32'({b_cause, b_fch, b_mask, b_done}), 32'd0);
            chk_restart = 1'b0;
        end
        for (int t = 0; t < n; t++) begin
            for (int w = 0; w < NUM_CH * WIDTH / 32; w++) dut_vec[w*32 +: 32] = $urandom();
            ref_vec = dut_vec;
            for (int i = 0; i < NUM_CH; i++) begin
                if (diff_q[t][i]) begin
                    bp = rnd_bit ? int'($urandom_range(WIDTH - 1, 0)) : 7;
                    ref_vec[i*WIDTH + bp] = ~ref_vec[i*WIDTH + bp];
                end
            end
            verify = ver_q[t]; ch_en = en_q[t]; dut_hlt = dh_q[t]; ref_hlt = rh_q[t];
            stall = st_q[t]; flush = fl_q[t];
            tick();
            if (t == probe_t) begin
                check("probe_mask", 32'(a_mask), 32'(probe_mask));
                check("probe_done", 32'(a_done), 32'd1);
            end
        end
        verify = 1'b0; stall = 1'b0; flush = 1'b0; dut_hlt = 1'b0; ref_hlt = 1'b0;
    endtask

    // Walks the recorded run cycle by cycle and applies the verdict rules directly.
    task automatic model(input int max_err, input int hlt_skew, input int timeout, input int cnt_w);
        int err, skew, sc, fc, fch, fcy, st, cause, cyc, sat;
        logic [8:0] m, mask;
        err = 0; skew = 0; sc = 0; fc = 0; fch = 0; fcy = 0;
        st = 1; cause = 0; cyc = LEN; mask = '0; sat = (1 << cnt_w) - 1;
        for (int t = 0; t < LEN && st == 1; t++) begin
            m = diff_q[t] & en_q[t];
            if (ver_q[t]) begin
                mask = m;
                if (m != 0) begin
                    if (err == 0) begin
                        fcy = t;
                        for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) fch = i;
                    end
                    if (err < sat) err++;
                end
            end
            if (st_q[t] && sc < sat) sc++;
            if (fl_q[t] && fc < sat) fc++;
            skew = (dh_q[t] != rh_q[t]) ? skew + 1 : 0;
            if (err >= max_err) begin st = 3; cause = 1; end
            else if (skew > hlt_skew) begin st = 3; cause = 3; end
            else if (dh_q[t] && rh_q[t]) st = 2;
            else if (t == timeout - 1) begin st = 3; cause = 2; end
            if (st != 1) cyc = t;
        end
        ex[0] = st; ex[1] = cause; ex[2] = err; ex[3] = fch; ex[4] = fcy;
        ex[5] = cyc; ex[6] = sc; ex[7] = fc; ex[8] = int'(mask); ex[9] = (st >= 2) ? 1 : 0;
    endtask

    task automatic cmp(input string who, input logic [1:0] s, input logic [1:0] c, input logic d,
                       input logic [15:0] e, input logic [3:0] fch, input logic [31:0] fcy,
                       input logic [31:0] cyc, input logic [15:0] st, input logic [15:0] fl,
                       input logic [8:0] mk);
        check({who, "_state"}, 32'(s), 32'(ex[0]));
        check({who, "_cause"}, 32'(c), 32'(ex[1]));
        check({who, "_err"}, 32'(e), 32'(ex[2]));
        check({who, "_first_ch"}, 32'(fch), 32'(ex[3]));
        check({who, "_first_cycle"}, fcy, 32'(ex[4]));
        check({who, "_cycle"}, cyc, 32'(ex[5]));
        check({who, "_stall"}, 32'(st), 32'(ex[6]));
        check({who, "_flush"}, 32'(fl), 32'(ex[7]));
        check({who, "_mask"}, 32'(mk), 32'(ex[8]));
        check({who, "_done"}, 32'(d), 32'(ex[9]));
    endtask

    task automatic check_both(input string tag);
        model(1, 2, 100, 16);
        cmp({tag, "_a"}, a_state, a_cause, a_done, a_err, a_fch, a_fcy, a_cyc, a_st, a_fl, a_mask);
        model(3, 0, 60, 4);
        cmp({tag, "_b"}, b_state, b_cause, b_done, 16'(b_err), b_fch, b_fcy, b_cyc,
            16'(b_st), 16'(b_fl), b_mask);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ctl", 32'({a_state, a_done, a_cause, a_mask, a_fch, b_state, b_done, b_cause}), 32'd0);
        check("rst_cnt", 32'(a_err) | 32'(a_st) | 32'(a_fl) | a_cyc | a_fcy | 32'(b_err), 32'd0);
        rst_n = 1'b1;
        tick();

        clear_stim(); set_halts(40, 40); apply(LEN);
        check_both("clean");
        check("clean_state", 32'(a_state), 32'd2);
        check("clean_cycle", a_cyc, 32'd40);

        clear_stim(); diff_q[12] = 9'h010; ver_q[12] = 1'b1; set_halts(40, 40);
        probe_t = 12; probe_mask = 9'h010;
        apply(LEN);
        probe_t = -1;
        check_both("mism");
        check("mism_first", {28'd0, a_fch}, 32'd4);
        check("mism_fcy", a_fcy, 32'd12);
        check("mism_cause", 32'(a_cause), 32'd1);

        clear_stim(); diff_q[12] = 9'h010; ver_q[12] = 1'b1; en_q[12] = 9'h1EF; set_halts(40, 40);
        apply(LEN);
        check_both("masked");
        check("masked_state", 32'(a_state), 32'd2);

        clear_stim(); set_halts(40, 40);
        diff_q[5] = 9'h002; ver_q[5] = 1'b1;
        diff_q[9] = 9'h100; ver_q[9] = 1'b1;
        diff_q[14] = 9'h030; ver_q[14] = 1'b1;
        apply(LEN);
        check_both("maxerr");
        check("maxerr_err", 32'(b_err), 32'd3);
        check("maxerr_cycle", b_cyc, 32'd14);

        chk_restart = 1'b1;
        clear_stim(); set_halts(20, 23); apply(LEN);
        check_both("skew3");
        check("skew3_cause", 32'(a_cause), 32'd3);

        clear_stim(); set_halts(20, 22); apply(LEN);
        check_both("skew2");
        check("skew2_state", 32'(a_state), 32'd2);

        clear_stim(); set_halts(LEN, LEN);
        for (int t = 0; t < LEN; t++) st_q[t] = 1'b1;
        apply(LEN);
        check_both("tmo");
        check("tmo_cycle", a_cyc, 32'd99);
        check("tmo_cause", 32'(a_cause), 32'd2);
        check("sat_stall", 32'(b_st), 32'd15);

        for (int k = 0; k < 6; k++) begin
            gen_random(); apply(LEN);
            check_both($sformatf("rnd%0d", k));
        end

        clear_stim(); set_halts(LEN, LEN);
        for (int t = 0; t < LEN; t++) st_q[t] = 1'b1;
        apply(50);
        check("midrun_state", 32'(a_state), 32'd1);
        check("midrun_cycle", a_cyc, 32'd50);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ctl", 32'({a_state, a_done, a_cause, a_mask, a_fch, b_state, b_done, b_cause}), 32'd0);
        check("arst_cnt", 32'(a_err) | 32'(a_st) | 32'(a_fl) | a_cyc | a_fcy | 32'(b_st) | b_cyc, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
